clk_div_ctrl: RTL and testbench

Runtime-programmable clock-divider controller for the divide-by-N clock generation path. It owns a mod-N period counter and the 50%-duty output stage for both even and odd N. It accepts divide-ratio changes over a valid/ready handshake and applies them only at output-period boundaries, so the output never glitches. It also sequences clean start and stop of the divided clock from a run enable.

---
 rtl/clk_div_ctrl.sv | 107 ++++++++++
 tb/tb_clk_div_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable divide-by-N clock generator.
// Mod-N period counter with a 50%-duty output stage for even and odd N,
// glitch-free ratio changes applied only at period boundaries, and clean
// start/stop sequencing from a run enable.
module clk_div_ctrl #(
  parameter int DIV_W       = 4,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             req_valid,
  input  logic [DIV_W-1:0] req_div,
  output logic             req_ready,
  output logic             clk_out,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy,
  output logic             period_start,
  output logic             err
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  typedef enum logic [1:0] {IDLE, RUN, PEND, STOPPING} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] cur_nxt;
  logic [DIV_W-1:0] pend_div, pend_nxt;
  logic             hi_pos, hi_neg;
  logic             accept, legal, wrap;

  // Handshake and status decode depend on state only, keeping them out of the
  // next-state process so accept never loops back through it.
  assign req_ready    = (state == IDLE) || (state == RUN);
  assign busy         = (state == PEND) || (state == STOPPING);
  assign period_start = (state != IDLE) && (cnt == '0);
  assign accept       = req_valid && req_ready;
  assign legal        = (req_div >= TWO);
  assign wrap         = (cnt == cur_div - ONE);
  assign clk_out      = hi_pos | hi_neg;

  // Next-state, counter and ratio selection; a new ratio only lands at a wrap
  // (or while idle) so the current period always completes at the old N.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wrap ? '0 : cnt + ONE;
    cur_nxt   = cur_div;
    pend_nxt  = pend_div;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept && legal) cur_nxt = req_div;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        // A request accepted together with en falling still goes to PEND;
        // PEND then stops after switching, giving one period at the new N.
        if (accept && legal) begin
          pend_nxt  = req_div;
          state_nxt = PEND;
        end else if (!en) begin
          state_nxt = STOPPING;
        end
      end
      PEND: begin
        if (wrap) begin
          cur_nxt   = pend_div;
          state_nxt = en ? RUN : STOPPING;
        end
      end
      STOPPING: begin
        if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, ratio registers plus the posedge half of the output stage.
  // hi_pos uses floor(N/2) for both parities; odd N gets its extra half cycle
  // from hi_neg.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= DIV_W'(DEFAULT_DIV);
      pend_div <= '0;
      hi_pos   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_div  <= cur_nxt;
      pend_div <= pend_nxt;
      hi_pos   <= (state != IDLE) && (cnt < (cur_div >> 1));
      err      <= accept && !legal;
    end
  end

  // Negedge phase: stretches the high time by half a cycle for odd N.
  always_ff @(negedge clk_in) begin
    if (rst) hi_neg <= 1'b0;
    else     hi_neg <= cur_div[0] & hi_pos;
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: clk_out is sampled every half cycle and
// compared with hand-derived waveforms, plus handshake/status checks.
module tb_clk_div_ctrl;
  localparam int DIV_W = 4;

  logic             clk_in = 1'b0;
  logic             rst, en, req_valid;
  logic [DIV_W-1:0] req_div;
  logic             req_ready, clk_out, busy, period_start, err;
  logic [DIV_W-1:0] cur_div;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  clk_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(5)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .req_valid(req_valid),
    .req_div(req_div), .req_ready(req_ready), .clk_out(clk_out),
    .cur_div(cur_div), .busy(busy), .period_start(period_start), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; req_valid = 1'b0; req_div = '0;
    tick;
    rst = 1'b0;
  endtask

  // Sample clk_out 1ns after each of n edges (posedge first, MSB = earliest);
  // period_start is captured at the posedge samples only.
  task automatic run_halves(input int n, output logic [31:0] co, output logic [31:0] ps);
    co = '0; ps = '0;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) @(posedge clk_in); else @(negedge clk_in);
      #1;
      co = {co[30:0], clk_out};
      if (i % 2 == 0) ps = {ps[30:0], period_start};
    end
  endtask

  initial begin
    logic [31:0] co, ps;

    // Reset state
    rst = 1'b1; en = 1'b0; req_valid = 1'b0; req_div = '0;
    tick; tick;
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_cur_div", 32'(cur_div), 5);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pstart", 32'(period_start), 0);
    chk("rst_err", 32'(err), 0);

    // Default N=5: 2.5 cycles high per 5-cycle period
    rst = 1'b0; en = 1'b1;
    run_halves(20, co, ps);
    chk("n5_wave", co, 32'b00111110000011111000);
    chk("n5_pstart", ps, 32'b1000010000);

    // Illegal request in IDLE, then N=4 loaded in IDLE
    do_reset;
    req_valid = 1'b1; req_div = 4'd0;
    tick;
    chk("idle_ill_err", 32'(err), 1);
    chk("idle_ill_div", 32'(cur_div), 5);
    req_div = 4'd4;
    tick;
    req_valid = 1'b0;
    chk("idle_load_div", 32'(cur_div), 4);
    chk("idle_load_err", 32'(err), 0);
    en = 1'b1;
    run_halves(16, co, ps);
    chk("n4_wave", co, 32'b0011110000111100);
    chk("n4_pstart", ps, 32'b10001000);

    // Running N=5, request N=3 at cnt=1
    do_reset;
    en = 1'b1;
    tick; tick;
    req_valid = 1'b1; req_div = 4'd3;
    chk("run_ready", 32'(req_ready), 1);
    tick;
    req_valid = 1'b0;
    chk("pend_busy", 32'(busy), 1);
    chk("pend_ready", 32'(req_ready), 0);
    chk("pend_old_div", 32'(cur_div), 5);
    run_halves(16, co, ps);
    chk("chg_wave", co, 32'b1000001110001110);
    chk("chg_pstart", ps, 32'b00100100);
    chk("chg_new_div", 32'(cur_div), 3);
    chk("chg_busy", 32'(busy), 0);

    // Illegal request while running
    req_valid = 1'b1; req_div = 4'd1;
    tick;
    req_valid = 1'b0;
    chk("run_ill_err", 32'(err), 1);
    chk("run_ill_div", 32'(cur_div), 3);
    chk("run_ill_busy", 32'(busy), 0);
    tick;
    chk("run_ill_err_clr", 32'(err), 0);
    chk("run_ill_ready", 32'(req_ready), 1);

    // N=7, en dropped at cnt=2: period completes, then idle
    do_reset;
    req_valid = 1'b1; req_div = 4'd7;
    tick;
    req_valid = 1'b0; en = 1'b1;
    tick; tick; tick;
    en = 1'b0;
    tick;
    chk("stop_busy", 32'(busy), 1);
    chk("stop_ready", 32'(req_ready), 0);
    run_halves(10, co, ps);
    chk("stop_wave", co, 32'b1000000000);
    chk("stop_pstart", ps, 0);
    chk("stop_idle_busy", 32'(busy), 0);
    chk("stop_idle_ready", 32'(req_ready), 1);
    chk("stop_div", 32'(cur_div), 7);

    // Reset while a ratio change is pending
    do_reset;
    en = 1'b1;
    tick; tick;
    req_valid = 1'b1; req_div = 4'd3;
    tick;
    req_valid = 1'b0;
    chk("prst_busy", 32'(busy), 1);
    chk("prst_clk_hi", 32'(clk_out), 1);
    rst = 1'b1;
    tick;
    chk("prst_clk_out", 32'(clk_out), 0);
    chk("prst_div", 32'(cur_div), 5);
    chk("prst_busy_clr", 32'(busy), 0);
    rst = 1'b0;
    run_halves(10, co, ps);
    chk("prst_wave", co, 32'b0011111000);
    chk("prst_after_div", 32'(cur_div), 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
